// File: rtl/led_recv.sv
// led_recv: receive side of the LED serial link.
// Oversamples the cko/sdo pair in the clk domain, deserialises MSB-first into
// WORD_W-bit words and delimits frames by an idle gap of GAP_CNT clk cycles
// with no cko rising edge.
//
// Ports:
//   clk         system clock (150 MHz)
//   rst         synchronous, active-high reset
//   cko_i       serial clock from the transmitter (asynchronous)
//   sdo_i       serial data, valid at cko rising edge
//   data_out    last completed word, MSB = first bit received
//   data_valid  1-cycle pulse when data_out updates
//   word_idx    index of the word on data_out within its frame (saturates at LED_NUM)
//   frame_done  1-cycle pulse when a frame of exactly LED_NUM whole words ends
//   frame_err   1-cycle pulse when a frame ends malformed
//   frame_cnt   (LED_RECV_STAT_EN only) count of frame_done pulses, wraps
//   err_cnt     (LED_RECV_STAT_EN only) count of frame_err pulses, wraps
//
// Optional feature macro: LED_RECV_STAT_EN adds the frame_cnt/err_cnt counters.
module led_recv #(
  parameter int unsigned LED_NUM = 4,
  parameter int unsigned WORD_W  = 128,
  parameter int unsigned GAP_CNT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cko_i,
  input  logic                      sdo_i,
  output logic [WORD_W-1:0]         data_out,
  output logic                      data_valid,
  output logic [$clog2(LED_NUM):0]  word_idx,
  output logic                      frame_done,
  output logic                      frame_err
`ifdef LED_RECV_STAT_EN
  ,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               err_cnt
`endif
);

  localparam int unsigned IW = $clog2(LED_NUM) + 1;
  // word_cnt must hold LED_NUM + 1 to flag long frames
  localparam int unsigned CW = $clog2(LED_NUM + 2);
  localparam int unsigned BW = $clog2(WORD_W + 1);
  localparam int unsigned GW = $clog2(GAP_CNT + 1);

  localparam logic [CW-1:0] LedNumC  = CW'(LED_NUM);
  localparam logic [CW-1:0] CntMax   = CW'(LED_NUM + 1);
  localparam logic [BW-1:0] WordLast = BW'(WORD_W);
  localparam logic [GW-1:0] GapLast  = GW'(GAP_CNT - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRecv = 1'b1;

  // Input synchronisers
  logic cko_s1_q, cko_s2_q, cko_s3_q;
  logic sdo_s1_q, sdo_s2_q;
  logic rise;

  assign rise = cko_s2_q & ~cko_s3_q;

  logic [0:0]        state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic [IW-1:0]     word_idx_q, word_idx_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;

  logic [WORD_W-1:0] shifted;
  logic [BW-1:0]     bit_cnt_inc;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    gap_d        = gap_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    word_idx_d   = word_idx_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    shifted     = {shift_q[WORD_W-2:0], sdo_s2_q};
    bit_cnt_inc = bit_cnt_q + BW'(1);

    if (rise) begin
      // A rise always wins: it clears the gap counter before it can expire.
      // In IDLE bit_cnt is already 0, so the same path starts a new frame.
      state_d = StRecv;
      shift_d = shifted;
      gap_d   = '0;
      if (bit_cnt_inc == WordLast) begin
        data_out_d   = shifted;
        data_valid_d = 1'b1;
        word_idx_d   = (word_cnt_q >= LedNumC) ? IW'(LED_NUM) : IW'(word_cnt_q);
        if (word_cnt_q != CntMax) begin
          word_cnt_d = word_cnt_q + CW'(1);
        end
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_inc;
      end
    end else if (state_q == StRecv) begin
      if (gap_q == GapLast) begin
        // Gap expired: classify the frame and return to IDLE.
        if ((bit_cnt_q == '0) && (word_cnt_q == LedNumC)) begin
          frame_done_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        word_cnt_d = '0;
        bit_cnt_d  = '0;
        gap_d      = '0;
        state_d    = StIdle;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end else begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cko_s1_q     <= 1'b0;
      cko_s2_q     <= 1'b0;
      cko_s3_q     <= 1'b0;
      sdo_s1_q     <= 1'b0;
      sdo_s2_q     <= 1'b0;
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      gap_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      word_idx_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cko_s1_q     <= cko_i;
      cko_s2_q     <= cko_s1_q;
      cko_s3_q     <= cko_s2_q;
      sdo_s1_q     <= sdo_i;
      sdo_s2_q     <= sdo_s1_q;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      gap_q        <= gap_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      word_idx_q   <= word_idx_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign word_idx   = word_idx_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

`ifdef LED_RECV_STAT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (frame_done_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (frame_err_d) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_led_recv.sv
// tb_led_recv: self-checking bench for led_recv.
// Drives cko/sdo as a transmitter would, records every output pulse and
// compares against frame-level expectations (word list, index, frame outcome).
module tb_led_recv;

  localparam int unsigned LED_NUM = 4;
  localparam int unsigned WORD_W  = 128;
  localparam int unsigned GAP_CNT = 16;

  logic                     clk;
  logic                     rst;
  logic                     cko_i;
  logic                     sdo_i;
  logic [WORD_W-1:0]        data_out;
  logic                     data_valid;
  logic [$clog2(LED_NUM):0] word_idx;
  logic                     frame_done;
  logic                     frame_err;
`ifdef LED_RECV_STAT_EN
  logic [15:0]              frame_cnt;
  logic [15:0]              err_cnt;
`endif

  led_recv #(
    .LED_NUM (LED_NUM),
    .WORD_W  (WORD_W),
    .GAP_CNT (GAP_CNT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cko_i      (cko_i),
    .sdo_i      (sdo_i),
    .data_out   (data_out),
    .data_valid (data_valid),
    .word_idx   (word_idx),
    .frame_done (frame_done),
`ifdef LED_RECV_STAT_EN
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`else
    .frame_err  (frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observed output events
  logic [WORD_W-1:0] obs_data[$];
  int                obs_idx[$];
  int                n_done;
  int                n_ferr;
  int                n_overlap;
  int                valid_cyc;
  int                done_cyc;
  int                set_cyc;

  always @(negedge clk) begin
    if (data_valid) begin
      obs_data.push_back(data_out);
      obs_idx.push_back(int'(word_idx));
      valid_cyc = cyc;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (frame_err) n_ferr++;
    if (data_valid && frame_done) n_overlap++;
  end

  // Expected statistics since the last reset
  int exp_frames = 0;
  int exp_errs   = 0;

  task automatic chk(input string name, input logic [WORD_W-1:0] act,
                     input logic [WORD_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_data = {};
    obs_idx  = {};
    n_done   = 0;
    n_ferr   = 0;
  endtask

  // One serial bit: data changes while cko is low, cko then rises.
  task automatic send_bit(input logic b, input bit jitter);
    int lo;
    int hi;
    lo = jitter ? int'($urandom_range(5, 2)) : 3;
    hi = jitter ? int'($urandom_range(5, 2)) : 2;
    sdo_i = b;
    repeat (lo) tick();
    cko_i   = 1'b1;
    set_cyc = cyc;
    repeat (hi) tick();
    cko_i = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input int nbits, input bit jitter);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[WORD_W-1-i], jitter);
    end
  endtask

  function automatic logic [WORD_W-1:0] fixed_word(input int i);
    logic [WORD_W-1:0] w;
    case (i % 4)
      0:       w = 128'h0123456789ABCDEF0123456789ABCDEF;
      1:       w = {WORD_W{1'b1}};
      2:       w = '0;
      default: w = {16{8'hA5}};
    endcase
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    int n_words;
    int extra_bits;
    bit jitter;
    bit rnd;
    int exp_valids;
    bit exp_done;
    bit exp_err;
  } vec_t;

  vec_t vecs[8];
  vec_t clean_vec;
  vec_t err_vec;

  // Send one frame, let the gap expire, and compare everything observed.
  task automatic run_vec(input vec_t v, input string tag);
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] sent[$];
    int exp_idx;
    sent = {};
    clear_obs();
    for (int i = 0; i < v.n_words; i++) begin
      w = v.rnd ? rand_word() : fixed_word(i);
      sent.push_back(w);
      send_word(w, WORD_W, v.jitter);
      if (i == v.n_words - 1) begin
        repeat (2) tick();
        // cko_i first sampled one edge after set_cyc; valid two edges later
        chk({tag, " latency"}, WORD_W'(valid_cyc - set_cyc), WORD_W'(3));
      end
    end
    if (v.extra_bits > 0) begin
      w = rand_word();
      send_word(w, v.extra_bits, v.jitter);
    end
    repeat (GAP_CNT + 8) tick();

    chk({tag, " n_valid"}, WORD_W'(obs_data.size()), WORD_W'(v.exp_valids));
    for (int i = 0; i < sent.size(); i++) begin
      if (i < obs_data.size()) begin
        exp_idx = (i < int'(LED_NUM)) ? i : int'(LED_NUM);
        chk($sformatf("%s data[%0d]", tag, i), obs_data[i], sent[i]);
        chk($sformatf("%s idx[%0d]", tag, i), WORD_W'(obs_idx[i]), WORD_W'(exp_idx));
      end
    end
    chk({tag, " frame_done"}, WORD_W'(n_done), WORD_W'(v.exp_done));
    chk({tag, " frame_err"}, WORD_W'(n_ferr), WORD_W'(v.exp_err));
    if (v.exp_done) begin
      chk({tag, " gap_timing"}, WORD_W'(done_cyc - valid_cyc), WORD_W'(GAP_CNT));
    end
    if (v.exp_done) exp_frames++;
    if (v.exp_err) exp_errs++;
  endtask

  initial begin
    rst       = 1'b1;
    cko_i     = 1'b0;
    sdo_i     = 1'b0;
    n_overlap = 0;
    valid_cyc = 0;
    done_cyc  = 0;
    set_cyc   = 0;
    clear_obs();

    //            words extra jit rnd valids done err
    vecs[0] = '{4,     0,   0,  0,  4,     1,   0};
    vecs[1] = '{0,     100, 0,  0,  0,     0,   1};
    vecs[2] = '{4,     0,   0,  1,  4,     1,   0};
    vecs[3] = '{3,     0,   0,  1,  3,     0,   1};
    vecs[4] = '{5,     0,   0,  1,  5,     0,   1};
    vecs[5] = '{4,     0,   1,  0,  4,     1,   0};
    vecs[6] = '{2,     50,  1,  1,  2,     0,   1};
    vecs[7] = '{4,     0,   1,  1,  4,     1,   0};
    clean_vec = '{4, 0, 0, 1, 4, 1, 0};
    err_vec   = '{1, 7, 0, 1, 1, 0, 1};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset data_out", data_out, '0);
    chk("reset data_valid", WORD_W'(data_valid), '0);
    chk("reset word_idx", WORD_W'(word_idx), '0);
    chk("reset frame_done", WORD_W'(frame_done), '0);
    chk("reset frame_err", WORD_W'(frame_err), '0);

    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset in the middle of word 1
    clear_obs();
    send_word(rand_word(), WORD_W, 1'b0);
    send_word(rand_word(), 64, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_frames = 0;
    exp_errs   = 0;
    chk("midrst data_out", data_out, '0);
    chk("midrst data_valid", WORD_W'(data_valid), '0);
    chk("midrst word_idx", WORD_W'(word_idx), '0);
    chk("midrst frame_done", WORD_W'(frame_done), '0);
    chk("midrst frame_err", WORD_W'(frame_err), '0);
    clear_obs();
    repeat (GAP_CNT + 8) tick();
    chk("midrst no valid", WORD_W'(obs_data.size()), '0);
    chk("midrst no done", WORD_W'(n_done), '0);
    chk("midrst no err", WORD_W'(n_ferr), '0);
    run_vec(clean_vec, "postrst");

`ifdef LED_RECV_STAT_EN
    run_vec(clean_vec, "stat_c2");
    run_vec(err_vec, "stat_e1");
    run_vec(clean_vec, "stat_c3");
    run_vec(vecs[3], "stat_e2");
    chk("frame_cnt", WORD_W'(frame_cnt), WORD_W'(exp_frames));
    chk("err_cnt", WORD_W'(err_cnt), WORD_W'(exp_errs));
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    run_vec(clean_vec, "stat_wrap");
    chk("frame_cnt wrap", WORD_W'(frame_cnt), '0);
    chk("err_cnt hold", WORD_W'(err_cnt), WORD_W'(exp_errs));
`endif

    chk("valid/done overlap", WORD_W'(n_overlap), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
